// File: rtl/display_source_arbiter.sv
// display_source_arbiter
// Round-robin owner selection for the shared 4-digit seven-segment display.
// The owner keeps the display for at least HOLD_TICKS cycles while others wait,
// source 0 can optionally preempt, and dispVal tracks the owner's value live.
module display_source_arbiter #(
  parameter int HOLD_TICKS = 5000000,
  parameter int CNT_W      = 23,
  parameter bit PRIO0      = 1'b1
) (
  input  logic        clock5,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  output logic [15:0] dispVal,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        switch_p
);

  typedef enum logic {IDLE, HOLD} state_t;

  // Dwell count saturates here; reaching it makes the owner eligible for rotation.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_TICKS - 1);

  state_t            state_reg, state_next;
  logic [3:0]        grant_reg, grant_next;
  logic [1:0]        owner_reg, owner_next;
  logic [15:0]       disp_reg, disp_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        rr_reg, rr_next;
  logic              switch_reg, switch_next;

  logic [15:0]       val_arr [4];
  logic [3:0]        owner_oh;
  logic [3:0]        others;
  logic              take;
  logic [1:0]        win;

  assign val_arr[0] = val0;
  assign val_arr[1] = val1;
  assign val_arr[2] = val2;
  assign val_arr[3] = val3;

  // One-hot form of the current owner, used to mask it out of the contenders.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_owner_oh
      assign owner_oh[gi] = (owner_reg == 2'(gi));
    end
  endgenerate

  assign others = req & ~owner_oh;

  // First set bit of r, searching upward from start and wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next-state logic: decide whether a new owner is taken, released, or kept.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    owner_next  = owner_reg;
    disp_next   = disp_reg;
    cnt_next    = cnt_reg;
    rr_next     = rr_reg;
    switch_next = 1'b0;
    take        = 1'b0;
    win         = 2'd0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
          win  = (PRIO0 && req[0]) ? 2'd0 : pick(req, rr_reg);
        end
      end
      HOLD: begin
        if (PRIO0 && req[0] && (owner_reg != 2'd0)) begin
          // Urgent source takes over at once; the rotation pointer is left alone.
          take = 1'b1;
          win  = 2'd0;
        end else if (!req[owner_reg]) begin
          // Owner let go: move the pointer past it, hand over or fall idle.
          rr_next = owner_reg + 2'd1;
          if (|req) begin
            take = 1'b1;
            win  = pick(req, owner_reg + 2'd1);
          end else begin
            grant_next = 4'b0000;
            state_next = IDLE;
          end
        end else if ((cnt_reg == CNT_MAX) && (|others) && !(PRIO0 && (owner_reg == 2'd0))) begin
          // Dwell expired under contention; urgent source 0 only yields on release.
          take = 1'b1;
          win  = pick(others, owner_reg + 2'd1);
        end else begin
          disp_next = val_arr[owner_reg];
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase

    if (take) begin
      grant_next  = 4'b0001 << win;
      owner_next  = win;
      disp_next   = val_arr[win];
      cnt_next    = '0;
      switch_next = 1'b1;
      state_next  = HOLD;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock5) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= 4'b0000;
      owner_reg  <= 2'd0;
      disp_reg   <= 16'h0000;
      cnt_reg    <= '0;
      rr_reg     <= 2'd0;
      switch_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      owner_reg  <= owner_next;
      disp_reg   <= disp_next;
      cnt_reg    <= cnt_next;
      rr_reg     <= rr_next;
      switch_reg <= switch_next;
    end
  end

  assign dispVal  = disp_reg;
  assign grant    = grant_reg;
  assign owner    = owner_reg;
  assign busy     = |grant_reg;
  assign switch_p = switch_reg;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter: two instances share inputs,
// one with urgent source 0 (PRIO0=1) and one plain round-robin (PRIO0=0).
module tb_display_source_arbiter;

  logic        clock5;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] vtab [4];
  logic [15:0] val0, val1, val2, val3;

  logic [15:0] disp_1, disp_0;
  logic [3:0]  grant_1, grant_0;
  logic [1:0]  owner_1, owner_0;
  logic        busy_1, busy_0;
  logic        switch_1, switch_0;

  int tests_run;
  int tests_failed;

  assign val0 = vtab[0];
  assign val1 = vtab[1];
  assign val2 = vtab[2];
  assign val3 = vtab[3];

  display_source_arbiter #(.HOLD_TICKS(4), .CNT_W(3), .PRIO0(1'b1)) dut (
    .clock5(clock5), .reset(reset), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .dispVal(disp_1), .grant(grant_1), .owner(owner_1),
    .busy(busy_1), .switch_p(switch_1)
  );

  display_source_arbiter #(.HOLD_TICKS(4), .CNT_W(3), .PRIO0(1'b0)) dut_rr (
    .clock5(clock5), .reset(reset), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .dispVal(disp_0), .grant(grant_0), .owner(owner_0),
    .busy(busy_0), .switch_p(switch_0)
  );

  initial clock5 = 1'b0;
  always #5 clock5 = ~clock5;

  task automatic tick();
    @(posedge clock5);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    int         idx;
    logic [3:0] exp_g;
    tests_run    = 0;
    tests_failed = 0;
    vtab[0] = 16'hDEAD;
    vtab[1] = 16'h1111;
    vtab[2] = 16'hBEEF;
    vtab[3] = 16'h3333;
    req   = 4'b0000;
    reset = 1'b1;
    tick();
    chk("reset_grant",  16'(grant_1), 16'h0);
    chk("reset_disp",   disp_1, 16'h0);
    chk("reset_owner",  16'(owner_1), 16'h0);
    chk("reset_busy",   16'(busy_1), 16'h0);
    chk("reset_switch", 16'(switch_1), 16'h0);
    reset = 1'b0;

    // 1: reset in the middle of a hold
    req = 4'b1111;
    tick();
    chk("t1_grant",  16'(grant_1), 16'h1);
    chk("t1_switch", 16'(switch_1), 16'h1);
    chk("t1_disp",   disp_1, 16'hDEAD);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t1_rst_grant",  16'(grant_1), 16'h0);
    chk("t1_rst_disp",   disp_1, 16'h0);
    chk("t1_rst_switch", 16'(switch_1), 16'h0);
    chk("t1_rst_busy",   16'(busy_1), 16'h0);
    reset = 1'b0;
    req   = 4'b0000;
    tick();

    // 2: single requester, live value tracking, release
    req = 4'b0100;
    tick();
    chk("t2_grant",  16'(grant_1), 16'h4);
    chk("t2_disp",   disp_1, 16'hBEEF);
    chk("t2_switch", 16'(switch_1), 16'h1);
    chk("t2_owner",  16'(owner_1), 16'h2);
    vtab[2] = 16'h1234;
    tick();
    chk("t2_track",   disp_1, 16'h1234);
    chk("t2_switch0", 16'(switch_1), 16'h0);
    req = 4'b0000;
    tick();
    chk("t2_idle_grant", 16'(grant_1), 16'h0);
    chk("t2_idle_disp",  disp_1, 16'h1234);
    chk("t2_idle_sw",    16'(switch_1), 16'h0);
    vtab[2] = 16'hBEEF;

    // 3: rotation on the plain round-robin instance, starting from pointer 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1110;
    for (int i = 0; i < 16; i++) begin
      tick();
      idx   = 1 + (i / 4) % 3;
      exp_g = 4'b0001 << idx;
      chk("t3_grant",  16'(grant_0), 16'(exp_g));
      chk("t3_switch", 16'(switch_0), (i % 4 == 0) ? 16'h1 : 16'h0);
      chk("t3_disp",   disp_0, vtab[idx]);
    end

    // 4: no contention, the owner keeps the display
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_grant",  16'(grant_1), 16'h2);
      chk("t4_switch", 16'(switch_1), 16'h0);
    end

    // 5: preemption by source 0
    req = 4'b0100;
    tick();
    chk("t5_grant2",  16'(grant_1), 16'h4);
    chk("t5_switch2", 16'(switch_1), 16'h1);
    tick();
    req = 4'b0101;
    tick();
    chk("t5_pre_grant",  16'(grant_1), 16'h1);
    chk("t5_pre_disp",   disp_1, 16'hDEAD);
    chk("t5_pre_switch", 16'(switch_1), 16'h1);
    chk("t5_pre_owner",  16'(owner_1), 16'h0);
    chk("t5_rr_nopre",   16'(grant_0), 16'h4);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_hold0",   16'(grant_1), 16'h1);
    chk("t5_hold0sw", 16'(switch_1), 16'h0);
    req = 4'b0100;
    tick();
    chk("t5_back_grant",  16'(grant_1), 16'h4);
    chk("t5_back_disp",   disp_1, 16'hBEEF);
    chk("t5_back_switch", 16'(switch_1), 16'h1);

    // 6: release to idle, then pointer wrap
    req = 4'b1000;
    tick();
    chk("t6_grant3", 16'(grant_1), 16'h8);
    chk("t6_disp3",  disp_1, 16'h3333);
    req = 4'b0000;
    tick();
    chk("t6_idle_grant", 16'(grant_1), 16'h0);
    chk("t6_idle_busy",  16'(busy_1), 16'h0);
    chk("t6_idle_disp",  disp_1, 16'h3333);
    chk("t6_idle_sw",    16'(switch_1), 16'h0);
    chk("t6_idle_owner", 16'(owner_1), 16'h3);
    tick();
    chk("t6_idle_owner2", 16'(owner_1), 16'h3);
    req = 4'b0011;
    tick();
    chk("t6_wrap_grant", 16'(grant_1), 16'h1);
    req = 4'b0000;
    tick();
    req = 4'b1010;
    tick();
    chk("t6_ptr_grant", 16'(grant_1), 16'h2);
    chk("t6_ptr_disp",  disp_1, 16'h1111);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
